mips_cpu_harvard: RTL and testbench
===================================

// Module: mips_cpu_harvard
// PURPOSE
//  Single-cycle MIPS-I integer core, Harvard bus (separate instruction and data ports).
//  Executes one instruction per enabled clock; memories respond combinationally.
//  register_v0 exposes $2 for bench observation.
//  Top-level CPU block; memories live outside it.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  PC value loaded on reset
// PORTS
//  clk             in   1   single clock, all state updates on rising edge
//  reset           in   1   synchronous, active-high
//  active          out  1   1 while running; 0 after halt
//  register_v0     out  32  current contents of $2 (combinational from regfile)
//  clk_enable      in   1   0 freezes all architectural state (PC, regs, active)
//  instr_address   out  32  = PC
//  instr_readdata  in   32  instruction at PC, valid same cycle
//  data_address    out  32  rs + sign_ext(imm16) for loads/stores, else don't-care
//  data_write      out  1   1 during sw only
//  data_read       in/out: out 1  1 during lw only
//  data_writedata  out  32  rt value during sw
//  data_readdata   in   32  load data, valid same cycle as data_read
// BEHAVIOUR
//  - Clock/reset fixed: one clock clk; reset is synchronous and active-high.
//  - Reset (sampled at posedge): PC<=RESET_VECTOR, all 32 GPRs<=0, active<=1,
//    pending branch cleared. data_read=data_write=0 while reset is high.
//  - Every enabled posedge commits one instruction: rd/rt write, PC update.
//    Results visible on register_v0 immediately after the edge.
//  - $0 always reads 0; writes to $0 discarded.
//  - Loads complete in the same cycle: lw rt <= data_readdata at the edge.
//    Addresses are byte addresses; low two bits assumed 00 (no exception).
//  - Supported R-type (funct):
//    addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav,
//    jr, jalr.
//  - Supported I/J-type:
//    addiu, andi, ori, xori (zero-ext), slti, sltiu, lui, lw, sw,
//    beq, bne, j, jal.
//  - slt/slti: signed 32-bit compare, result 32'h1 or 32'h0.
//    sltu/sltiu: unsigned compare (sltiu sign-extends imm first).
//  - addu/addiu/subu wrap modulo 2^32, no overflow trap.
//  - Branch/jump delay slot honoured:
//    - Instruction after a taken branch/jump always executes.
//    - Branch target = PC+4 + (sext(imm)<<2).
//    - j/jal target = {PC+4[31:28], idx, 2'b00}.
//    - jal/jalr link = PC+8 (jal links to $31).
//  - Halt: jump/jr to address 0. After its delay slot commits, active<=0 and
//    all state freezes until reset.
//  - Unknown opcodes execute as nop (PC+4, no write).
//  - clk_enable=0: no register, PC or active change. Bus outputs still reflect
//    the current decode.
//  - Reset asserted mid-program overrides any pending branch and any write.
// STRUCTURE
//  - mips_pkg: opcode and funct localparams/enums, ALU-op typedef,
//    RESET_VECTOR default.
//  - Sub-module mips_regfile: 32x32, two async read ports, one sync write port,
//    sync reset, plus v0 tap.
//  - Decode, ALU and PC/branch logic stay in the top-level module.
// TESTING
//  - Reset: hold reset 1 cycle.
//    -> instr_address=32'hBFC00000, active=1, register_v0=0.
//  - lw r2..r16, offset 0 from $0, data_readdata=0x12345678 (then +0xdcba1234*k):
//    -> data_read=1, data_write=0 each cycle; data_address=0.
//    -> r2 holds 0x12345678 after the edge.
//  - slt r(i+15), r(i-1), r(i) for i=2..16, then addiu $2, r(i+15), 0:
//    -> v0 = ($signed(r[i-1]) < $signed(r[i])) ? 1 : 0.
//    -> e.g. slt 0 vs 0x12345678 gives 1.
//  - sw $3, 4($0) with $3=0xDEADBEEF:
//    -> data_write=1, data_address=4, data_writedata=0xDEADBEEF, data_read=0.
//  - beq $0,$0,+2 followed by addiu $2,$0,5:
//    -> delay-slot addiu commits (v0=5); next PC = branch PC+12.
//  - jr $0 (with nop in delay slot):
//    -> active drops to 0 after the delay slot.
//    -> further edges change nothing; clk_enable=0 likewise freezes v0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS-I core: opcodes, R-type functs,
// the ALU operation type and the default reset vector.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_if.sv
// Harvard bus between the core (cpu side) and external instruction/data memories.
interface mips_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport cpu (
    output instr_address, data_address, data_write, data_read, data_writedata,
    input  instr_readdata, data_readdata
  );

  modport mem (
    input  instr_address, data_address, data_write, data_read, data_writedata,
    output instr_readdata, data_readdata
  );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two async reads, one sync write,
// $0 hardwired to zero, plus a tap of $2 for observation.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
  assign v0_o     = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I integer core with separate instruction and data buses.
// Decode, ALU and PC/branch sequencing live here; GPRs are in mips_regfile.
module mips_cpu_harvard
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  mips_if.cpu         bus
);

  logic [31:0] pc_q, pc_d, npc_q, npc_d;
  logic        active_q, active_d;

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val;
  logic [31:0] br_target, j_target, jump_target;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic [4:0]  shamt;
  logic        wr_en, link, is_lw, is_sw, taken, commit;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign instr    = bus.instr_readdata;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign sa       = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0, instr[15:0]};

  assign br_target = pc_q + 32'd4 + (imm_sext << 2);
  assign j_target  = {pc_q[31:28] + 4'(pc_q[27:2] == 26'h3FF_FFFF), instr[25:0], 2'b00};

  always_comb begin
    alu_op      = ALU_ADD;
    alu_b       = imm_sext;
    shamt       = sa;
    wr_en       = 1'b0;
    wr_addr     = rt;
    link        = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    taken       = 1'b0;
    jump_target = br_target;
    case (opcode)
      OP_SPECIAL: begin
        alu_b   = rt_val;
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; shamt = rs_val[4:0]; end
          F_SRLV: begin alu_op = ALU_SRL; shamt = rs_val[4:0]; end
          F_SRAV: begin alu_op = ALU_SRA; shamt = rs_val[4:0]; end
          F_JR:   begin wr_en = 1'b0; taken = 1'b1; jump_target = rs_val; end
          F_JALR: begin link = 1'b1; taken = 1'b1; jump_target = rs_val; end
          F_ADDU: alu_op = ALU_ADD;
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          default: wr_en = 1'b0;
        endcase
      end
      OP_J:     begin taken = 1'b1; jump_target = j_target; end
      OP_JAL:   begin taken = 1'b1; jump_target = j_target; link = 1'b1;
                      wr_en = 1'b1; wr_addr = 5'd31; end
      OP_BEQ:   taken = (rs_val == rt_val);
      OP_BNE:   taken = (rs_val != rt_val);
      OP_ADDIU: wr_en = 1'b1;
      OP_SLTI:  begin alu_op = ALU_SLT;  wr_en = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; wr_en = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND; alu_b = imm_zext; wr_en = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;  alu_b = imm_zext; wr_en = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR; alu_b = imm_zext; wr_en = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI; alu_b = imm_zext; wr_en = 1'b1; end
      OP_LW:    begin is_lw = 1'b1; wr_en = 1'b1; end
      OP_SW:    is_sw = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_y = rs_val + alu_b;
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_XOR:  alu_y = rs_val ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_val | alu_b);
      ALU_SLT:  alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'h0, rs_val < alu_b};
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_y = {alu_b[15:0], 16'h0};
      default:  alu_y = '0;
    endcase
  end

  assign wr_data = link  ? pc_q + 32'd8 :
                   is_lw ? bus.data_readdata : alu_y;
  assign commit  = active_q && clk_enable && !reset;

  mips_regfile u_regfile (
    .clk      (clk),
    .rst      (reset),
    .we_i     (commit && wr_en),
    .waddr_i  (wr_addr),
    .wdata_i  (wr_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val),
    .v0_o     (register_v0)
  );

  // npc_q holds the delay-slot successor; the jump decision lands one step later.
  assign pc_d     = npc_q;
  assign npc_d    = taken ? jump_target : npc_q + 32'd4;
  assign active_d = (npc_q != 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      npc_q    <= RESET_VECTOR + 32'd4;
      active_q <= 1'b1;
    end else if (commit) begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      active_q <= active_d;
    end
  end

  assign active             = active_q;
  assign bus.instr_address  = pc_q;
  assign bus.data_address   = rs_val + imm_sext;
  assign bus.data_writedata = rt_val;
  assign bus.data_read      = is_lw && active_q && !reset;
  assign bus.data_write     = is_sw && active_q && !reset;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed bench for mips_cpu_harvard: the bench plays instruction/data memory
// by driving the bus inputs each cycle and checks against hand-derived values.
module tb_mips_cpu_harvard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m [32];

  mips_if bus ();

  mips_cpu_harvard dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic present(input logic [31:0] ins, input logic [31:0] rdat);
    bus.instr_readdata = ins;
    bus.data_readdata  = rdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    present(NOP, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    present(enc_i(6'h23, 5'd0, 5'd2, 16'h0), 32'hFFFF_FFFF);
    tick();
    checks++;
    if (bus.data_read !== 1'b0 || bus.data_write !== 1'b0) begin
      errors++; $display("FAIL reset_bus rd=%b wr=%b required 0 0", bus.data_read, bus.data_write);
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    present(NOP, 32'h0);
    checks++;
    if (bus.instr_address !== 32'hBFC0_0000) begin
      errors++; $display("FAIL reset_pc got %h required %h", bus.instr_address, 32'hBFC0_0000);
    end
    checks++;
    if (active !== 1'b1) begin
      errors++; $display("FAIL reset_active got %b required 1", active);
    end
    checks++;
    if (register_v0 !== 32'h0) begin
      errors++; $display("FAIL reset_v0 got %h required 0", register_v0);
    end
  endtask

  task automatic test_lw();
    logic [31:0] rdat;
    for (int k = 0; k < 15; k++) begin
      rdat = 32'h1234_5678 + 32'hDCBA_1234 * k;
      present(enc_i(6'h23, 5'd0, 5'(2 + k), 16'h0), rdat);
      checks++;
      if (bus.data_read !== 1'b1 || bus.data_write !== 1'b0 || bus.data_address !== 32'h0) begin
        errors++;
        $display("FAIL lw_bus k=%0d rd=%b wr=%b addr=%h required 1 0 0", k,
                 bus.data_read, bus.data_write, bus.data_address);
      end
      tick();
      m[2 + k] = rdat;
      checks++;
      if (register_v0 !== 32'h1234_5678) begin
        errors++; $display("FAIL lw_v0 k=%0d got %h required 12345678", k, register_v0);
      end
      checks++;
      if (bus.instr_address !== 32'hBFC0_0000 + 32'(4 * (k + 1))) begin
        errors++; $display("FAIL lw_pc k=%0d got %h required %h", k, bus.instr_address,
                           32'hBFC0_0000 + 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_slt();
    logic [31:0] exp;
    for (int i = 2; i <= 16; i++) begin
      present(enc_r(5'(i - 1), 5'(i), 5'(i + 15), 5'd0, 6'h2A), 32'h0);
      tick();
      exp = ($signed(m[i - 1]) < $signed(m[i])) ? 32'h1 : 32'h0;
      m[i + 15] = exp;
      present(enc_i(6'h09, 5'(i + 15), 5'd2, 16'h0), 32'h0);
      tick();
      m[2] = exp;
      checks++;
      if (register_v0 !== exp) begin
        errors++; $display("FAIL slt i=%0d got %h required %h", i, register_v0, exp);
      end
    end
  endtask

  task automatic test_sw_alu();
    do_reset();
    present(enc_i(6'h0F, 5'd0, 5'd3, 16'hDEAD), 32'h0); tick();
    present(enc_i(6'h0D, 5'd3, 5'd3, 16'hBEEF), 32'h0); tick();
    present(enc_i(6'h2B, 5'd0, 5'd3, 16'h0004), 32'h0);
    checks++;
    if (bus.data_write !== 1'b1 || bus.data_read !== 1'b0 || bus.data_address !== 32'h4 ||
        bus.data_writedata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_bus wr=%b rd=%b addr=%h wdata=%h required 1 0 4 deadbeef",
               bus.data_write, bus.data_read, bus.data_address, bus.data_writedata);
    end
    tick();
    checks++;
    if (register_v0 !== 32'h0) begin
      errors++; $display("FAIL sw_nowrite got %h required 0", register_v0);
    end
    present(enc_r(5'd0, 5'd3, 5'd2, 5'd4, 6'h03), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'hFDEA_DBEE) begin
      errors++; $display("FAIL sra got %h required fdeadbee", register_v0);
    end
    present(enc_r(5'd0, 5'd3, 5'd2, 5'd4, 6'h02), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'h0DEA_DBEE) begin
      errors++; $display("FAIL srl got %h required 0deadbee", register_v0);
    end
    present(enc_i(6'h0E, 5'd3, 5'd2, 16'hFFFF), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'hDEAD_4110) begin
      errors++; $display("FAIL xori got %h required dead4110", register_v0);
    end
    present(enc_i(6'h0B, 5'd0, 5'd2, 16'hFFFF), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'h1) begin
      errors++; $display("FAIL sltiu got %h required 1", register_v0);
    end
    present(enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF), 32'h0); tick();
    present(enc_r(5'd2, 5'd3, 5'd2, 5'd0, 6'h23), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'h2152_4110) begin
      errors++; $display("FAIL subu got %h required 21524110", register_v0);
    end
    present(enc_i(6'h09, 5'd0, 5'd0, 16'h0005), 32'h0); tick();
    present(enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h21), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'h0) begin
      errors++; $display("FAIL zero_reg got %h required 0", register_v0);
    end
  endtask

  task automatic test_branch();
    do_reset();
    present(enc_i(6'h04, 5'd0, 5'd0, 16'h0002), 32'h0); tick();
    checks++;
    if (bus.instr_address !== 32'hBFC0_0004) begin
      errors++; $display("FAIL beq_slot_pc got %h required bfc00004", bus.instr_address);
    end
    present(enc_i(6'h09, 5'd0, 5'd2, 16'h0005), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'h5 || bus.instr_address !== 32'hBFC0_000C) begin
      errors++; $display("FAIL beq_taken v0=%h pc=%h required 5 bfc0000c", register_v0, bus.instr_address);
    end
    present(enc_i(6'h05, 5'd0, 5'd0, 16'h0002), 32'h0); tick();
    present(NOP, 32'h0); tick();
    checks++;
    if (bus.instr_address !== 32'hBFC0_0014) begin
      errors++; $display("FAIL bne_not_taken got %h required bfc00014", bus.instr_address);
    end
  endtask

  task automatic test_jal();
    do_reset();
    present({6'h03, 26'h3F0_0040}, 32'h0); tick();
    present(NOP, 32'h0); tick();
    checks++;
    if (bus.instr_address !== 32'hBFC0_0100) begin
      errors++; $display("FAIL jal_target got %h required bfc00100", bus.instr_address);
    end
    present(enc_i(6'h09, 5'd31, 5'd2, 16'h0), 32'h0); tick();
    checks++;
    if (register_v0 !== 32'hBFC0_0008) begin
      errors++; $display("FAIL jal_link got %h required bfc00008", register_v0);
    end
  endtask

  task automatic test_enable();
    do_reset();
    present(enc_i(6'h09, 5'd0, 5'd2, 16'h0009), 32'h0); tick();
    clk_enable = 1'b0;
    present(enc_i(6'h23, 5'd0, 5'd2, 16'h0010), 32'hAAAA_5555);
    checks++;
    if (bus.data_read !== 1'b1 || bus.data_address !== 32'h10) begin
      errors++; $display("FAIL en_bus rd=%b addr=%h required 1 10", bus.data_read, bus.data_address);
    end
    tick();
    checks++;
    if (register_v0 !== 32'h9 || bus.instr_address !== 32'hBFC0_0004) begin
      errors++; $display("FAIL en_freeze v0=%h pc=%h required 9 bfc00004", register_v0, bus.instr_address);
    end
    clk_enable = 1'b1;
    tick();
    checks++;
    if (register_v0 !== 32'hAAAA_5555) begin
      errors++; $display("FAIL en_resume got %h required aaaa5555", register_v0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    present(enc_i(6'h04, 5'd0, 5'd0, 16'h000A), 32'h0); tick();
    reset = 1'b1;
    present(enc_i(6'h09, 5'd0, 5'd2, 16'h0009), 32'h0); tick();
    reset = 1'b0;
    checks++;
    if (register_v0 !== 32'h0 || bus.instr_address !== 32'hBFC0_0000) begin
      errors++; $display("FAIL rst_mid v0=%h pc=%h required 0 bfc00000", register_v0, bus.instr_address);
    end
    present(NOP, 32'h0); tick();
    checks++;
    if (bus.instr_address !== 32'hBFC0_0004) begin
      errors++; $display("FAIL rst_mid_branch got %h required bfc00004", bus.instr_address);
    end
  endtask

  task automatic test_halt();
    do_reset();
    present(enc_i(6'h09, 5'd0, 5'd2, 16'h0033), 32'h0); tick();
    present(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0); tick();
    checks++;
    if (active !== 1'b1) begin
      errors++; $display("FAIL halt_slot_active got %b required 1", active);
    end
    present(NOP, 32'h0); tick();
    checks++;
    if (active !== 1'b0 || bus.instr_address !== 32'h0) begin
      errors++; $display("FAIL halt active=%b pc=%h required 0 0", active, bus.instr_address);
    end
    present(enc_i(6'h09, 5'd0, 5'd2, 16'h0007), 32'h0); tick(); tick();
    checks++;
    if (register_v0 !== 32'h33 || bus.instr_address !== 32'h0 || active !== 1'b0) begin
      errors++; $display("FAIL halt_frozen v0=%h pc=%h active=%b required 33 0 0",
                         register_v0, bus.instr_address, active);
    end
    clk_enable = 1'b0;
    tick();
    checks++;
    if (register_v0 !== 32'h33) begin
      errors++; $display("FAIL halt_en_frozen got %h required 33", register_v0);
    end
    clk_enable = 1'b1;
  endtask

  initial begin
    bus.instr_readdata = NOP;
    bus.data_readdata  = 32'h0;
    test_reset();
    test_lw();
    test_slt();
    test_sw_alu();
    test_branch();
    test_jal();
    test_enable();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
